// File: rtl/random_range_gen.sv
// Galois-LFSR random source that returns values uniformly drawn from [0, limit-1]
// using masked rejection sampling, with a bounded number of retries per draw.
module random_range_gen #(
    parameter int                LFSR_W    = 16,
    parameter int                OUT_W     = 8,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    parameter int                MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req,
    input  logic [OUT_W-1:0]  limit,
    output logic              busy,
    output logic              valid,
    output logic [OUT_W-1:0]  data,
    output logic              retried_out
);
    localparam logic [31:0] TAPS_ALL = (LFSR_W == 16) ? 32'h0000_B400 :
                                       (LFSR_W == 24) ? 32'h00E1_0000 :
                                                        32'h8020_0003;
    localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
    localparam int                CNT_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [CNT_W-1:0]  LAST_TRY = CNT_W'(MAX_TRIES - 1);

    generate
        if (LFSR_W != 16 && LFSR_W != 24 && LFSR_W != 32) begin : g_bad_lfsr_w
            $error("random_range_gen: LFSR_W must be 16, 24 or 32");
        end
        if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
            $error("random_range_gen: OUT_W must be between 1 and LFSR_W");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("random_range_gen: SEED must be non-zero");
        end
        if (MAX_TRIES < 1) begin : g_bad_tries
            $error("random_range_gen: MAX_TRIES must be at least 1");
        end
    endgenerate

    typedef enum logic {IDLE, DRAW} state_t;

    state_t            state_reg, state_next;
    logic [LFSR_W-1:0] lfsr_reg, lfsr_next;
    logic [OUT_W-1:0]  limit_reg, limit_next;
    logic [CNT_W-1:0]  try_reg, try_next;
    logic [OUT_W-1:0]  data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              retried_reg, retried_next;
    logic              busy_reg;

    logic [LFSR_W-1:0] lfsr_step;
    logic [OUT_W-1:0]  limit_m1;
    logic [OUT_W-1:0]  mask;
    logic [OUT_W-1:0]  cand;

    assign lfsr_step = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1);

    // Smear every bit of (L-1) downwards: the result is the smallest 2^m-1 >= L-1.
    assign limit_m1 = limit_reg - OUT_W'(1);
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_mask
            assign mask[gi] = |limit_m1[OUT_W-1:gi];
        end
    endgenerate

    assign cand = lfsr_reg[OUT_W-1:0] & mask;

    always_comb begin
        state_next   = state_reg;
        limit_next   = limit_reg;
        try_next     = try_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        retried_next = retried_reg;

        // A zero seed would lock the LFSR, so it falls back to SEED.
        if (seed_load) begin
            lfsr_next = (seed_in == '0) ? SEED : seed_in;
        end else begin
            lfsr_next = lfsr_step;
        end

        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (limit <= OUT_W'(1)) begin
                        data_next    = '0;
                        valid_next   = 1'b1;
                        retried_next = 1'b0;
                    end else begin
                        limit_next = limit;
                        try_next   = '0;
                        state_next = DRAW;
                    end
                end
            end
            DRAW: begin
                if (cand < limit_reg) begin
                    data_next    = cand;
                    valid_next   = 1'b1;
                    retried_next = 1'b0;
                    state_next   = IDLE;
                end else if (try_reg == LAST_TRY) begin
                    // mask < 2L, so a rejected candidate minus L is always in range.
                    data_next    = cand - limit_reg;
                    valid_next   = 1'b1;
                    retried_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    try_next = try_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            lfsr_reg    <= SEED;
            limit_reg   <= '0;
            try_reg     <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            retried_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            limit_reg   <= limit_next;
            try_reg     <= try_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            retried_reg <= retried_next;
            busy_reg    <= (state_next == DRAW);
        end
    end

    assign busy        = busy_reg;
    assign valid       = valid_reg;
    assign data        = data_reg;
    assign retried_out = retried_reg;

endmodule

// File: tb/tb_random_range_gen.sv
// Self-checking bench for random_range_gen: randomized draws compared against
// a behavioural model of the LFSR and the rejection-sampling rules.
module tb_random_range_gen;
    localparam int MT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        req = 1'b0;
    logic [7:0]  limit = '0;

    logic        busy, valid, retried_out;
    logic [7:0]  data;
    logic        busy1, valid1, retried1;
    logic [7:0]  data1;

    int total = 0;
    int bad = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    random_range_gen #(.LFSR_W(16), .OUT_W(8), .SEED(16'hACE1), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .limit(limit), .busy(busy), .valid(valid), .data(data),
        .retried_out(retried_out)
    );

    random_range_gen #(.LFSR_W(16), .OUT_W(8), .SEED(16'hACE1), .MAX_TRIES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .limit(limit), .busy(busy1), .valid(valid1), .data(data1),
        .retried_out(retried1)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] lfsr_after(input logic [15:0] v, input logic ld,
                                               input logic [15:0] s);
        if (ld) return (s == 16'h0000) ? 16'hACE1 : s;
        return lfsr_step(v);
    endfunction

    function automatic int mask_for(input int lim);
        int m = 0;
        while (((1 << m) - 1) < (lim - 1)) m++;
        return (1 << m) - 1;
    endfunction

    // Reference LFSR: tracks the register value the design holds after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_after(m_lfsr, seed_load, seed_in);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0;
        seed_load = 1'b0;
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_valid", valid, 1'b0);
        check_val("rst_data", data, 8'h00);
        check_val("rst_retried", retried_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called on a negedge: issues one request and waits for its result.
    task automatic do_draw(input int lim, input logic ld, input logic [15:0] sd,
                           output logic [7:0] got_data);
        logic [15:0] s;
        int msk, cand, lat, exp_data, n;
        logic exp_retry;
        req = 1'b1;
        limit = lim[7:0];
        seed_load = ld;
        seed_in = sd;
        s = lfsr_after(m_lfsr, ld, sd);
        lat = 0;
        exp_data = 0;
        exp_retry = 1'b0;
        if (lim >= 2) begin
            msk = mask_for(lim);
            for (int k = 0; k < MT; k++) begin
                cand = int'(s[7:0]) & msk;
                if (cand < lim) begin
                    exp_data = cand;
                    lat = k + 1;
                    break;
                end
                if (k == MT - 1) begin
                    exp_data = cand - lim;
                    exp_retry = 1'b1;
                    lat = MT;
                end
                s = lfsr_step(s);
            end
        end
        @(negedge clk);
        req = 1'b0;
        seed_load = 1'b0;
        n = 1;
        while (!valid && n < 20) begin
            check_val("busy_in_draw", busy, 1'b1);
            @(negedge clk);
            n++;
        end
        check_val("valid_seen", valid, 1'b1);
        check_val("latency", n, lat + 1);
        check_val("data", data, exp_data);
        check_val("retried", retried_out, exp_retry);
        check_val("busy_done", busy, 1'b0);
        got_data = data;
        $display("draw limit=%0d data=%0d retried=%0b edges=%0d", lim, data, retried_out, n);
        @(negedge clk);
        check_val("valid_pulse", valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int extra;

        // First draw straight out of reset, limit 0xFF.
        apply_reset();
        do_draw(255, 1'b0, 16'h0000, d);
        check_val("first_draw_70", d, 8'h70);

        // limit 0x60: 0x70 rejected, 0x38 accepted.
        apply_reset();
        do_draw(96, 1'b0, 16'h0000, d);
        check_val("second_try_38", d, 8'h38);

        // Single-try instance falls back; main instance finishes a cycle later.
        apply_reset();
        req = 1'b1;
        limit = 8'h60;
        @(negedge clk);
        req = 1'b0;
        check_val("mt1_busy", busy1, 1'b1);
        check_val("mt1_novalid", valid1, 1'b0);
        @(negedge clk);
        check_val("mt1_valid", valid1, 1'b1);
        check_val("mt1_data", data1, 8'h10);
        check_val("mt1_retried", retried1, 1'b1);
        check_val("main_still_busy", busy, 1'b1);
        @(negedge clk);
        check_val("main_valid", valid, 1'b1);
        check_val("main_data", data, 8'h38);
        @(negedge clk);

        // Degenerate limits answer at the request edge.
        do_draw(0, 1'b0, 16'h0000, d);
        do_draw(1, 1'b0, 16'h0000, d);

        // Seed loads: zero falls back to ACE1, 0001 steps to B400.
        seed_load = 1'b1;
        seed_in = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        do_draw(255, 1'b0, 16'h0000, d);
        check_val("seed0_fallback", d, 8'h70);
        seed_load = 1'b1;
        seed_in = 16'h0001;
        @(negedge clk);
        seed_load = 1'b0;
        do_draw(255, 1'b0, 16'h0000, d);
        check_val("seed1_step_b400", d, 8'h00);
        do_draw(255, 1'b1, 16'h1234, d);
        check_val("seed_at_req", d, 8'h34);

        // Request while busy is ignored.
        apply_reset();
        req = 1'b1;
        limit = 8'h60;
        @(negedge clk);
        check_val("busy_req_busy", busy, 1'b1);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_val("busy_req_novalid", valid, 1'b0);
        @(negedge clk);
        check_val("busy_req_valid", valid, 1'b1);
        check_val("busy_req_data", data, 8'h38);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (valid) extra++;
        end
        check_val("no_queued_req", extra, 0);

        // Reset in the middle of a draw.
        req = 1'b1;
        limit = 8'h60;
        @(negedge clk);
        req = 1'b0;
        check_val("mid_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_valid", valid, 1'b0);
        check_val("mid_rst_data", data, 8'h00);
        check_val("mid_rst_retried", retried_out, 1'b0);
        extra = 0;
        @(negedge clk);
        if (valid) extra++;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid) extra++;
        end
        check_val("mid_rst_no_valid", extra, 0);

        // Long run with limit 10, occasionally reseeding at the request edge.
        for (int i = 0; i < 1000; i++) begin
            logic ld;
            ld = ($urandom_range(0, 7) == 0);
            do_draw(10, ld, 16'($urandom), d);
            check_val("below_10", (d < 8'd10) ? 1'b1 : 1'b0, 1'b1);
        end

        // Random limits across the whole range.
        for (int i = 0; i < 200; i++) begin
            int lim;
            lim = $urandom_range(0, 255);
            do_draw(lim, ($urandom_range(0, 3) == 0), 16'($urandom), d);
            if (lim >= 2) check_val("below_limit", (int'(d) < lim) ? 1'b1 : 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/random_range_gen.md
Name: random_range_gen

Overview:
- Parametrised successor to the free-running single-bit random source.
- Free-running Galois LFSR of configurable width, reseedable at runtime.
- On a request, returns one OUT_W-bit value uniformly drawn from [0, limit-1] using masked rejection sampling, with a bounded retry count.
- Feeds the mine placer, which issues one draw per board coordinate.

Parameters:
- LFSR_W, 16: LFSR width. Legal values are 16, 24 and 32; any other value is an elaboration error.
- OUT_W, 8: result width; must be ≤ LFSR_W.
- SEED, 16'hACE1 (zero-extended to LFSR_W): reset and fallback seed; must be non-zero.
- MAX_TRIES, 8: maximum rejection-sampling attempts per draw; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- seed_load  in  1  single-cycle strobe: load seed_in into the LFSR.
- seed_in  in  LFSR_W  new seed value.
- req  in  1  draw request; sampled only in IDLE.
- limit  in  OUT_W  exclusive upper bound; captured with req.
- busy  out  1  high while state ≠ IDLE.
- valid  out  1  one-cycle pulse: data is valid.
- data  out  OUT_W  drawn value; held until the next valid.
- retried_out  out  1  qualifies valid; high when the fallback path was used.

Behaviour:
- Reset (rst_n=0, asynchronous): lfsr=SEED, state=IDLE, busy=0, valid=0, data=0, retried_out=0, try counter=0.
- LFSR
  - Galois right-shift, advances on every clk edge regardless of state.
  - Update rule: lsb=1 → (lfsr>>1)^TAPS, else lfsr>>1.
  - TAPS: 16 → 16'hB400, 24 → 24'hE10000, 32 → 32'h80200003.
- Seed load
  - seed_load=1 loads seed_in instead of stepping; a zero seed_in loads SEED, so the LFSR never locks up.
  - Legal in any state; an in-progress draw continues on the new sequence.
- Mask
  - Combinational, from the captured limit L.
  - mask = smallest (2^m − 1) ≥ L−1. Examples: L=96 → 8'h7F, L=10 → 8'h0F.
- States: IDLE, DRAW.
- IDLE
  - req=1 with L≥2: capture L, clear try counter, go to DRAW.
  - req=1 with L∈{0,1}: at the same edge set data=0, valid=1, retried_out=0, and stay in IDLE.
  - req=0: remain in IDLE.
- DRAW, each edge
  - Compute cand = lfsr[OUT_W-1:0] & mask, using the current pre-step register value.
  - cand < L: data=cand, valid=1, retried_out=0, go to IDLE.
  - Otherwise, if try count+1 == MAX_TRIES: data=cand−L (always < L because cand < 2L), valid=1, retried_out=1, go to IDLE.
  - Otherwise: increment try count and stay in DRAW.
- Latency
  - Accept on first try: valid is asserted at the second edge after req is sampled, i.e. 1 cycle in DRAW.
  - Worst case: MAX_TRIES cycles in DRAW.
- valid is a single-cycle pulse; it is cleared on every edge where it is not being set.
- req while busy is ignored and not queued. req may be held high; a new draw starts on the first IDLE edge.
- limit changes while busy have no effect on the current draw.
- busy is registered and equals (state==DRAW).
- Back-to-back: with req held high, an accepted draw returns to IDLE and the next draw starts one edge later.
- Reset mid-draw aborts immediately: no valid is emitted and all registers return to reset values.

Test Plan:
- LFSR_W=16, OUT_W=8, defaults; release rst_n; req=1 at first edge, limit=8'hFF.
  - Required: lfsr sequence ACE1, E270, 7138, 389C; busy=1 for one cycle; valid pulse with data=8'h70, retried_out=0.
- Same start, limit=8'h60.
  - Required: cand 0x70 rejected; next cand 0x38 accepted; valid one cycle later than the previous case with data=8'h38.
- MAX_TRIES=1, limit=8'h60, same start.
  - Required: valid after 1 DRAW cycle with data=8'h10, retried_out=1.
- limit=0 and limit=1 requests in IDLE.
  - Required: valid at the request edge, data=0, busy never asserted.
- seed_load=1 with seed_in=0, then separately with seed_in=16'h0001.
  - Required: lfsr reloads ACE1, then 0001; next step after 0001 is B400.
- Assert rst_n=0 mid-DRAW; pulse req while busy.
  - Required: immediate return to reset values with no valid; the request made while busy produces no extra valid; a 1000-draw run with limit=10 yields data<10 on every valid.
